// File: rtl/sram_responder.sv
// SRAM-style slave: word store with byte-lane writes, 1-cycle read latency,
// out-of-range error reporting and saturating read/write access counters.
module sram_responder #(
    parameter int          IDX_W = 12,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sram_en,
    input  logic [3:0]       sram_wen,
    input  logic [31:0]      sram_addr,
    input  logic [31:0]      sram_wdata,
    output logic [31:0]      sram_rdata,
    output logic             err_valid,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    input  logic             clr_cnt
);
    localparam int          DEPTH    = 1 << IDX_W;
    localparam logic [31:0] WIN_MASK = ~((32'd4 << IDX_W) - 32'd1);

    logic [31:0]      r_mem [0:DEPTH-1];
    logic [31:0]      r_rdata;
    logic             r_err_valid;
    logic [31:0]      r_err_addr;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;

    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_oor;

    assign w_idx      = sram_addr[IDX_W+1:2];
    assign w_in_range = (sram_addr & WIN_MASK) == BASE;
    assign w_rd_ok    = sram_en && w_in_range && (sram_wen == 4'b0000);
    assign w_wr_ok    = sram_en && w_in_range && (sram_wen != 4'b0000);
    assign w_oor      = sram_en && !w_in_range;

    // Store has no reset so contents survive rst; rst still blocks writes.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata     <= 32'h0;
            r_err_valid <= 1'b0;
            r_err_addr  <= 32'h0;
        end else begin
            r_err_valid <= w_oor;
            if (w_oor) begin
                r_err_addr <= sram_addr;
            end
            if (w_rd_ok) begin
                r_rdata <= r_mem[w_idx];
            end else if (w_oor && (sram_wen == 4'b0000)) begin
                r_rdata <= 32'h0;
            end
        end
    end

    // Clear wins over any increment on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (clr_cnt) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_ok && (r_rd_cnt != {CNT_W{1'b1}})) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_wr_ok && (r_wr_cnt != {CNT_W{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    assign sram_rdata = r_rdata;
    assign err_valid  = r_err_valid;
    assign err_addr   = r_err_addr;
    assign rd_cnt     = r_rd_cnt;
    assign wr_cnt     = r_wr_cnt;
endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (IDX_W=12, BASE=0, CNT_W=3).
module tb_sram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] sram_rdata;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [2:0]  rd_cnt;
    logic [2:0]  wr_cnt;
    logic        clr_cnt = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mdl [int];
    logic [31:0] exp_q [$];
    logic [2:0]  m_rd = 3'd0;
    logic [2:0]  m_wr = 3'd0;
    logic        m_err = 1'b0;
    logic [31:0] m_erra = 32'h0;

    sram_responder #(.IDX_W(12), .BASE(32'h0), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .err_valid(err_valid), .err_addr(err_addr), .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt), .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    // Drive one request cycle and advance the model; returns #1 after the edge.
    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wd, input logic clr);
        int k;
        logic [31:0] w;
        @(negedge clk);
        sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wd; clr_cnt = clr;
        m_err = 1'b0;
        if (en) begin
            if (addr < 32'h0000_4000) begin
                k = int'(addr[13:2]);
                w = mdl.exists(k) ? mdl[k] : 32'h0;
                if (wen == 4'h0) begin
                    exp_q.push_back(w);
                    if (m_rd != 3'd7) m_rd = m_rd + 3'd1;
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (wen[i]) w[8*i +: 8] = wd[8*i +: 8];
                    mdl[k] = w;
                    if (m_wr != 3'd7) m_wr = m_wr + 3'd1;
                end
            end else begin
                m_err = 1'b1;
                m_erra = addr;
                if (wen == 4'h0) exp_q.push_back(32'h0);
            end
        end
        if (clr) begin
            m_rd = 3'd0;
            m_wr = 3'd0;
        end
        @(posedge clk);
        #1;
        sram_en = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
            n_chk++;
            if (sram_rdata !== 32'h0 || err_valid !== 1'b0 || rd_cnt !== 3'd0 || wr_cnt !== 3'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: rdata=%h err=%b rd=%0d wr=%0d, want 0", c,
                         sram_rdata, err_valid, rd_cnt, wr_cnt);
            end
        end
        n_chk++;
        if (err_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_err_addr: got %h want 0", err_addr);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (sram_rdata !== e || sram_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_read: got %h want %h", sram_rdata, e);
        end
        n_chk++;
        if (rd_cnt !== 3'd1 || wr_cnt !== 3'd1) begin
            n_err++;
            $display("FAIL write_read_cnt: rd=%0d wr=%0d want 1/1", rd_cnt, wr_cnt);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        n_chk++;
        if (sram_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL idle_hold: got %h want deadbeef", sram_rdata);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] e;
        drive(1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0);
        drive(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 1'b0);
        n_chk++;
        if (sram_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_holds_rdata: got %h want deadbeef", sram_rdata);
        end
        drive(1'b1, 4'h0, 32'h23, 32'h0, 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (sram_rdata !== e || sram_rdata !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL byte_lanes: got %h want %h", sram_rdata, e);
        end
        n_chk++;
        if (rd_cnt !== m_rd || wr_cnt !== m_wr) begin
            n_err++;
            $display("FAIL byte_lanes_cnt: rd=%0d wr=%0d want %0d/%0d", rd_cnt, wr_cnt, m_rd, m_wr);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] e;
        logic [2:0]  rd0, wr0;
        drive(1'b1, 4'hF, 32'h04, 32'hCAFEF00D, 1'b0);
        rd0 = m_rd; wr0 = m_wr;
        drive(1'b1, 4'h0, 32'h4000, 32'h0, 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (sram_rdata !== e || err_valid !== 1'b1 || err_addr !== 32'h4000) begin
            n_err++;
            $display("FAIL oor_read: rdata=%h err=%b eaddr=%h want %h 1 00004000",
                     sram_rdata, err_valid, err_addr, e);
        end
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        n_chk++;
        if (err_valid !== 1'b0 || err_addr !== 32'h4000) begin
            n_err++;
            $display("FAIL oor_pulse: err=%b eaddr=%h want 0 00004000", err_valid, err_addr);
        end
        drive(1'b1, 4'hF, 32'h4004, 32'h12345678, 1'b0);
        n_chk++;
        if (err_valid !== m_err || err_addr !== m_erra || rd_cnt !== rd0 || wr_cnt !== wr0) begin
            n_err++;
            $display("FAIL oor_write: err=%b eaddr=%h rd=%0d wr=%0d want 1 %h %0d %0d",
                     err_valid, err_addr, rd_cnt, wr_cnt, m_erra, rd0, wr0);
        end
        // Back-to-back out-of-range: err_valid stays up, err_addr tracks each edge
        drive(1'b1, 4'h0, 32'h8000, 32'h0, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b1, 4'h0, 32'hFFFF_FFF0, 32'h0, 1'b0);
        void'(exp_q.pop_front());
        n_chk++;
        if (err_valid !== 1'b1 || err_addr !== 32'hFFFF_FFF0) begin
            n_err++;
            $display("FAIL oor_b2b: err=%b eaddr=%h want 1 fffffff0", err_valid, err_addr);
        end
        drive(1'b1, 4'h0, 32'h04, 32'h0, 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (sram_rdata !== e || sram_rdata !== 32'hCAFEF00D || err_valid !== 1'b0) begin
            n_err++;
            $display("FAIL oor_store_unchanged: rdata=%h err=%b want %h 0", sram_rdata, err_valid, e);
        end
    endtask

    task automatic test_saturate_clear();
        logic [31:0] e;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        n_chk++;
        if (rd_cnt !== 3'd0 || wr_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL clr_idle: rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
        end
        for (int r = 0; r < 9; r++) begin
            drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
            e = exp_q.pop_front();
            n_chk++;
            if (sram_rdata !== e || rd_cnt !== m_rd) begin
                n_err++;
                $display("FAIL sat_read%0d: rdata=%h rd=%0d want %h %0d", r, sram_rdata, rd_cnt, e, m_rd);
            end
        end
        n_chk++;
        if (rd_cnt !== 3'd7) begin
            n_err++;
            $display("FAIL sat_stop: rd=%0d want 7", rd_cnt);
        end
        drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b1);
        void'(exp_q.pop_front());
        n_chk++;
        if (rd_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL clr_override: rd=%0d want 0", rd_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] e;
        drive(1'b1, 4'hF, 32'h30, 32'h55, 1'b0);
        drive(1'b1, 4'h0, 32'h4000, 32'h0, 1'b0);
        void'(exp_q.pop_front());
        @(negedge clk);
        sram_en = 1'b1; sram_wen = 4'hF; sram_addr = 32'h30; sram_wdata = 32'h66;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (sram_rdata !== 32'h0 || err_valid !== 1'b0 || err_addr !== 32'h0 ||
            rd_cnt !== 3'd0 || wr_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: rdata=%h err=%b eaddr=%h rd=%0d wr=%0d want all 0",
                     sram_rdata, err_valid, err_addr, rd_cnt, wr_cnt);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (sram_rdata !== 32'h0 || wr_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset_hold: rdata=%h wr=%0d want 0 0", sram_rdata, wr_cnt);
        end
        @(negedge clk);
        sram_en = 1'b0;
        rst = 1'b0;
        m_rd = 3'd0; m_wr = 3'd0; m_err = 1'b0; m_erra = 32'h0;
        drive(1'b1, 4'h0, 32'h30, 32'h0, 1'b0);
        e = exp_q.pop_front();
        n_chk++;
        if (sram_rdata !== e || sram_rdata !== 32'h55 || rd_cnt !== 3'd1 || wr_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset_persist: rdata=%h rd=%0d wr=%0d want 00000055 1 0",
                     sram_rdata, rd_cnt, wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_saturate_clear();
        test_reset_midstream();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
